// File: rtl/util_tx_playback.sv
// util_tx_playback: cyclic playback of a sample buffer onto an AXI-stream sink.
// A single-clock RAM holds up to 2**ADDR_WIDTH samples. A start pulse replays
// entries 0..length-1 repeatedly, and a stop pulse ends playback at the close
// of the current pass. A one-entry holding register sits between the RAM read
// port and the output register, so the stream sustains one beat per cycle and
// never has bubbles, even though the RAM has a read latency of one cycle.
// Optional feature: define UTIL_TX_PLAYBACK_LOOP_CNT_EN to enable the
// completed-pass counter on loop_count. Without it, loop_count is tied to 0.
module util_tx_playback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  start,
  input  logic                  stop,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  busy,
  output logic [15:0]           loop_count
);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, FINISH} state_t;

  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_q;      // RAM read register (holding slot)
  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;      // pass length captured at start
  logic [ADDR_WIDTH-1:0] rd_idx;     // next index to fetch
  logic                  q_vld;      // ram_q holds a fetched, unsent sample
  logic                  q_last;     // ram_q sample is index length-1
  logic                  t_last;     // output sample is index length-1

  logic                  start_ok;
  logic                  beat;
  logic                  load_out;
  logic                  rd_en;
  logic                  rd_wrap;
  logic [ADDR_WIDTH:0]   len_eff;

  // Handshake decode and fetch scheduling.
  // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
  always_comb begin
    start_ok = (state == IDLE) && start && (length != '0) && (length <= LEN_MAX);
    beat     = m_axis_tvalid && m_axis_tready;
    load_out = !m_axis_tvalid || m_axis_tready;
    // The first fetch happens on the start cycle, before len_q has been loaded.
    len_eff  = (state == IDLE) ? length : len_q;
    rd_wrap  = ({1'b0, rd_idx} == (len_eff - LEN_ONE));
    rd_en    = start_ok || ((state != IDLE) && (!q_vld || load_out));
  end

  // Sample buffer: synchronous write port and registered read port.
  // NOTE: the RAM array and its read register have no reset, so they map onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_idx];
  end

  // Playback control: state machine, fetch pointer, holding slot and output register.
  // NOTE: all state is updated with non-blocking assignments, so every read sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      len_q         <= '0;
      rd_idx        <= '0;
      q_vld         <= 1'b0;
      q_last        <= 1'b0;
      t_last        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (rd_en) begin
        rd_idx <= rd_wrap ? '0 : rd_idx + ADDR_WIDTH'(1);
        q_last <= rd_wrap;
        q_vld  <= 1'b1;
      end else if (load_out) begin
        q_vld  <= 1'b0;
      end

      if (load_out) begin
        m_axis_tvalid <= q_vld;
        if (q_vld) begin
          m_axis_tdata <= ram_q;
          t_last       <= q_last;
        end
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q <= length;
            busy  <= 1'b1;
            state <= stop ? FINISH : PREFETCH;
          end
        end
        PREFETCH: begin
          state <= stop ? FINISH : RUN;
        end
        RUN: begin
          if (stop) begin
            if (beat && t_last) begin
              // The stop coincides with the pass-closing beat, so playback ends here.
              state         <= IDLE;
              busy          <= 1'b0;
              rd_idx        <= '0;
              q_vld         <= 1'b0;
              m_axis_tvalid <= 1'b0;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          // Samples fetched past the end of the pass are discarded here.
          if (beat && t_last) begin
            state         <= IDLE;
            busy          <= 1'b0;
            rd_idx        <= '0;
            q_vld         <= 1'b0;
            m_axis_tvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UTIL_TX_PLAYBACK_LOOP_CNT_EN
  // Completed-pass counter: cleared on an accepted start, saturates at all ones.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      loop_count <= '0;
    end else if (start_ok) begin
      loop_count <= '0;
    end else if (beat && t_last && (loop_count != 16'hFFFF)) begin
      loop_count <= loop_count + 16'd1;
    end
  end
`else
  assign loop_count = '0;
`endif

endmodule

// File: tb/tb_util_tx_playback.sv
// Self-checking bench for util_tx_playback. It uses a table of start/length
// cases plus streaming runs with random backpressure. Every run is checked
// against a reference that is an array copy of the buffer, with the pass
// index and pass count computed arithmetically.
module tb_util_tx_playback;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 2**AW;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   length;
  logic          start;
  logic          stop;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          busy;
  logic [15:0]   loop_count;

  util_tx_playback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .length        (length),
    .start         (start),
    .stop          (stop),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy),
    .loop_count    (loop_count)
  );

  always #5 aclk = ~aclk;

  // Reference state
  logic [DW-1:0] model_mem [DEPTH];
  int exp_idx;
  int exp_len;
  int exp_loops;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int len;
    bit with_stop;
    bit exp_accept;
  } start_vec_t;

  start_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_lc();
`ifdef UTIL_TX_PLAYBACK_LOOP_CNT_EN
    return 16'(exp_loops);
`else
    return 16'h0000;
`endif
  endfunction

  // Advance one clock and sample just after the active edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    model_mem[addr] = data;
    step();
    wr_en = 1'b0;
  endtask

  // Pulse start (optionally with stop) and check the two-cycle launch latency.
  task automatic launch(input int len, input bit with_stop, input bit exp_accept);
    m_axis_tready = 1'b1;
    length = (AW+1)'(len);
    start  = 1'b1;
    stop   = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
    if (exp_accept) begin
      exp_idx   = 0;
      exp_len   = len;
      exp_loops = 0;
    end
    check("busy at start+1", busy, exp_accept);
    check("tvalid at start+1", m_axis_tvalid, 0);
    check("loop_count at start+1", loop_count, exp_lc());
    step();
    check("tvalid at start+2", m_axis_tvalid, exp_accept);
    check("busy at start+2", busy, exp_accept);
    if (exp_accept) check("tdata at start+2", m_axis_tdata, model_mem[0]);
  endtask

  // Stream and check every cycle against the reference. If stop_beat >= 0,
  // stop is pulsed once that many beats have been accepted. If stop_init is
  // set, the stop came together with start. The stream must end right after
  // the first beat that carries index len-1 once a stop has been seen.
  task automatic stream(input int max_cycles, input bit rnd, input int stop_beat,
                        input bit bg_start, input bit stop_init);
    bit stopping = stop_init;
    bit ended    = 1'b0;
    bit last;
    int beats    = 0;
    for (int c = 0; c < max_cycles && !ended; c++) begin
      check("tvalid streaming", m_axis_tvalid, 1);
      check("tdata", m_axis_tdata, model_mem[exp_idx]);
      check("loop_count", loop_count, exp_lc());
      check("busy streaming", busy, 1);
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      length        = (AW+1)'($urandom_range(0, 255));
      start         = bg_start && ($urandom_range(0, 15) == 0);
      stop          = (stop_beat >= 0) && (beats == stop_beat) && !stopping;
      if (stop) stopping = 1'b1;
      if (m_axis_tready) begin
        beats++;
        last    = (exp_idx == exp_len - 1);
        exp_idx = last ? 0 : exp_idx + 1;
        if (last && exp_loops < 65535) exp_loops++;
        if (last && stopping) ended = 1'b1;
      end
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    if (stop_beat >= 0 || stop_init) begin
      check("stream ended within budget", ended, 1);
      check("tvalid after last beat", m_axis_tvalid, 0);
      check("busy after last beat", busy, 0);
      check("loop_count after end", loop_count, exp_lc());
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_beats;

    vecs[0] = '{len: 0,   with_stop: 1'b0, exp_accept: 1'b0};
    vecs[1] = '{len: 129, with_stop: 1'b0, exp_accept: 1'b0};
    vecs[2] = '{len: 255, with_stop: 1'b0, exp_accept: 1'b0};
    vecs[3] = '{len: 1,   with_stop: 1'b1, exp_accept: 1'b1};
    vecs[4] = '{len: 128, with_stop: 1'b1, exp_accept: 1'b1};
    vecs[5] = '{len: 7,   with_stop: 1'b0, exp_accept: 1'b1};

    aresetn = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    length = '0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    exp_idx = 0; exp_len = 1; exp_loops = 0;

    // Asynchronous reset values, checked before any clock edge
    #3 aresetn = 1'b0;
    #1;
    check("reset tvalid", m_axis_tvalid, 0);
    check("reset tdata", m_axis_tdata, 0);
    check("reset busy", busy, 0);
    check("reset loop_count", loop_count, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Load mem[i] = i
    for (int i = 0; i < DEPTH; i++) write_word(i, DW'(i));

    // Stop in IDLE is a no-op
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    check("stop in idle busy", busy, 0);
    check("stop in idle tvalid", m_axis_tvalid, 0);

    // Full-rate playback of 120 samples, stop at beat 50 of pass 2
    launch(120, 1'b0, 1'b1);
    stream(400, 1'b0, 170, 1'b0, 1'b0);

    // Same stream under random backpressure, with ignored starts while busy
    launch(120, 1'b0, 1'b1);
    stream(3000, 1'b1, 130, 1'b1, 1'b0);

    // Table: start acceptance by length, and start together with stop
    for (int v = 0; v < 6; v++) begin
      launch(vecs[v].len, vecs[v].with_stop, vecs[v].exp_accept);
      if (vecs[v].exp_accept)
        stream(vecs[v].len * 2 + 20, 1'b0, vecs[v].with_stop ? -1 : 3, 1'b0, vecs[v].with_stop);
      step();
      check("idle after vector", busy, 0);
    end

    // length = 1 repeats mem[0]; the pass counter saturates
    write_word(0, 32'hDEADBEEF);
`ifdef UTIL_TX_PLAYBACK_LOOP_CNT_EN
    sat_beats = 65600;
`else
    sat_beats = 300;
`endif
    launch(1, 1'b0, 1'b1);
    stream(sat_beats + 10, 1'b0, sat_beats, 1'b0, 1'b0);

    // Reset mid-stream during a stall, then replay from mem[0] with previous RAM contents
    launch(120, 1'b0, 1'b1);
    stream(40, 1'b1, -1, 1'b0, 1'b0);
    m_axis_tready = 1'b0;
    step();
    check("tvalid held before reset", m_axis_tvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("mid-stream reset tvalid", m_axis_tvalid, 0);
    check("mid-stream reset busy", busy, 0);
    check("mid-stream reset loop_count", loop_count, 0);
    check("mid-stream reset tdata", m_axis_tdata, 0);
    exp_loops = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    check("idle after reset", busy, 0);
    launch(120, 1'b0, 1'b1);
    stream(1000, 1'b1, 125, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
